// File: rtl/ibex_efpga_if.sv
// Execute-stage CX responder: hands operands to the eFPGA fabric, waits out its latency, returns the result.
// Define IBEX_EFPGA_PERF_EN to build the busy-cycle and completed-op counters.
module ibex_efpga_if #(
  parameter int unsigned DELAY_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               kill_i,
  input  logic [1:0]         operator_i,
  input  logic [31:0]        operand_a_i,
  input  logic [31:0]        operand_b_i,
  input  logic [DELAY_W-1:0] delay_i,
  input  logic [31:0]        result_a_i,
  input  logic [31:0]        result_b_i,
  input  logic [31:0]        result_c_i,
  output logic [31:0]        fabric_op_a_o,
  output logic [31:0]        fabric_op_b_o,
  output logic               fabric_start_o,
  output logic               ready_o,
  output logic [31:0]        endresult_o,
  output logic               illegal_o,
  output logic [31:0]        busy_cycles_o,
  output logic [31:0]        ops_done_o
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        result_q, result_d;
  logic [1:0]         sel_op;
  logic [31:0]        mux_res;
  logic               live;

  assign fabric_op_a_o = operand_a_i;
  assign fabric_op_b_o = operand_b_i;
  assign live          = en_i & ~kill_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= 2'b00;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    unique case (state_q)
      IDLE: begin
        if (live) begin
          op_d = operator_i;
          if (delay_i != '0) begin
            cnt_d   = delay_i - DELAY_W'(1);
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        if (!live) begin
          state_d = IDLE;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DELAY_W'(1);
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fabric_start_o = 1'b0;
    ready_o        = 1'b0;
    unique case (state_q)
      IDLE: begin
        fabric_start_o = live;
        ready_o        = live & (delay_i == '0);
      end
      BUSY: ready_o = live & (cnt_q == '0);
      default: ready_o = 1'b0;
    endcase
  end

  // a zero-latency op completes before op_q is written, so use the live type
  assign sel_op = (state_q == IDLE) ? operator_i : op_q;

  always_comb begin
    mux_res = '0;
    unique case (sel_op)
      2'b00:   mux_res = result_a_i;
      2'b01:   mux_res = result_b_i;
      2'b10:   mux_res = result_c_i;
      default: mux_res = '0;
    endcase
  end

  assign illegal_o   = ready_o & (sel_op == 2'b11);
  assign result_d    = ready_o ? mux_res : result_q;
  assign endresult_o = ready_o ? mux_res : result_q;

`ifdef IBEX_EFPGA_PERF_EN
  logic [31:0] busy_q, ops_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
      ops_q  <= '0;
    end else begin
      if (en_i && !ready_o) busy_q <= busy_q + 32'd1;
      if (ready_o)          ops_q  <= ops_q + 32'd1;
    end
  end

  assign busy_cycles_o = busy_q;
  assign ops_done_o    = ops_q;
`else
  assign busy_cycles_o = '0;
  assign ops_done_o    = '0;
`endif

endmodule

// File: tb/tb_ibex_efpga_if.sv
// Bench for ibex_efpga_if: vector table through a result scoreboard plus
// hand sequences for abort, back-to-back and reset corners.
module tb_ibex_efpga_if;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, kill;
  logic [1:0]  op;
  logic [31:0] opa, opb;
  logic [3:0]  dly;
  logic [31:0] ra, rb, rc;
  logic [31:0] f_a, f_b, endres, busy_c, ops_c;
  logic        f_start, ready, illegal;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [3:0]  dly;
    logic [31:0] ra, rb, rc;
    logic [31:0] exp;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    logic        ill;
    int          lat;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[6];

  ibex_efpga_if #(.DELAY_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .en_i           (en),
    .kill_i         (kill),
    .operator_i     (op),
    .operand_a_i    (opa),
    .operand_b_i    (opb),
    .delay_i        (dly),
    .result_a_i     (ra),
    .result_b_i     (rb),
    .result_c_i     (rc),
    .fabric_op_a_o  (f_a),
    .fabric_op_b_o  (f_b),
    .fabric_start_o (f_start),
    .ready_o        (ready),
    .endresult_o    (endres),
    .illegal_o      (illegal),
    .busy_cycles_o  (busy_c),
    .ops_done_o     (ops_c)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b want %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e, got;
    int   cyc;
    bit   done;
    step();
    en = 1'b1; op = v.op; dly = v.dly;
    ra = v.ra; rb = v.rb; rc = v.rc;
    e.res = v.exp; e.ill = v.ill; e.lat = int'(v.dly) + 1;
    sb.push_back(e);
    cyc = 0; done = 0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      chk1("start_pulse", f_start, cyc == 1);
      if (ready) begin
        got = sb.pop_front();
        chk("result", endres, got.res);
        chk1("illegal", illegal, got.ill);
        chk("latency", 32'(cyc), 32'(got.lat));
        done = 1;
      end
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: got none want ready after %0d", e.lat);
      sb.delete();
    end
    step();
    en = 1'b0;
    @(negedge clk);
    chk("hold", endres, v.exp);
    chk1("ready_idle", ready, 1'b0);
  endtask

  initial begin
    logic [3:0] rdy_pat, st_pat;
    exp_t       e, got;
    rst_n = 1'b0; en = 1'b0; kill = 1'b0; op = 2'b00; dly = 4'd0;
    opa = 32'h13579BDF; opb = 32'h2468ACE0;
    ra = 32'h0; rb = 32'h0; rc = 32'h0;

    vecs[0] = '{2'b01, 4'd0,  32'h11111111, 32'hCAFE0001, 32'h22222222, 32'hCAFE0001, 1'b0};
    vecs[1] = '{2'b10, 4'd3,  32'hAAAA0000, 32'hBBBB0000, 32'h12345678, 32'h12345678, 1'b0};
    vecs[2] = '{2'b11, 4'd2,  32'h33333333, 32'h44444444, 32'h55555555, 32'h00000000, 1'b1};
    vecs[3] = '{2'b00, 4'd15, 32'hDEADBEEF, 32'h1, 32'h2, 32'hDEADBEEF, 1'b0};
    vecs[4] = '{2'b00, 4'd1,  32'h0F0F0F0F, 32'h3, 32'h4, 32'h0F0F0F0F, 1'b0};
    vecs[5] = '{2'b01, 4'd7,  32'h5, 32'hFFFFFFFF, 32'h6, 32'hFFFFFFFF, 1'b0};

    #2;
    chk("rst_op_a", f_a, 32'h13579BDF);
    chk("rst_op_b", f_b, 32'h2468ACE0);
    chk1("rst_ready", ready, 1'b0);
    chk1("rst_start", f_start, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk("rst_endres", endres, 32'h0);
    chk("rst_busy", busy_c, 32'h0);
    chk("rst_ops", ops_c, 32'h0);
    step(); step();
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // back-to-back: two delay-1 ops under one continuous en
    step();
    en = 1'b1; op = 2'b10; dly = 4'd1; rc = 32'h0BADF00D;
    e.res = 32'h0BADF00D; e.ill = 1'b0; e.lat = 2;
    sb.push_back(e); sb.push_back(e);
    rdy_pat = '0; st_pat = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy_pat[c] = ready;
      st_pat[c]  = f_start;
      if (ready && sb.size() > 0) begin
        got = sb.pop_front();
        chk("b2b_result", endres, got.res);
      end
      step();
    end
    en = 1'b0;
    chk("b2b_ready_pat", 32'(rdy_pat), 32'h0000000A);
    chk("b2b_start_pat", 32'(st_pat), 32'h00000005);
    chk("b2b_sb_empty", 32'(sb.size()), 32'h0);
    sb.delete();

    // kill mid-op, then a zero-latency op must start at once
    en = 1'b1; op = 2'b00; dly = 4'd5; ra = 32'h55555555;
    step();
    kill = 1'b1;
    @(negedge clk);
    chk1("kill_ready", ready, 1'b0);
    chk("kill_hold", endres, 32'h0BADF00D);
    step();
    kill = 1'b0; dly = 4'd0; op = 2'b01; rb = 32'h77777777;
    @(negedge clk);
    chk1("kill_idle_start", f_start, 1'b1);
    chk1("kill_idle_ready", ready, 1'b1);
    chk("kill_next_res", endres, 32'h77777777);
    step();
    en = 1'b0;

    // kill on the completion cycle wins
    step();
    en = 1'b1; op = 2'b00; dly = 4'd1; ra = 32'h99999999;
    step();
    kill = 1'b1;
    @(negedge clk);
    chk1("killdone_ready", ready, 1'b0);
    chk("killdone_hold", endres, 32'h77777777);
    step();
    kill = 1'b0; en = 1'b0;
    @(negedge clk);
    chk1("killdone_after", ready, 1'b0);
    chk("killdone_hold2", endres, 32'h77777777);
    step();
    en = 1'b1; dly = 4'd0;
    @(negedge clk);
    chk1("killdone_idle", ready, 1'b1);
    chk("killdone_res", endres, 32'h99999999);
    step();
    en = 1'b0;

    // en dropped while busy aborts the op
    step();
    en = 1'b1; op = 2'b10; dly = 4'd3; rc = 32'h44444444;
    step();
    en = 1'b0;
    @(negedge clk);
    chk1("enlow_ready", ready, 1'b0);
    chk("enlow_hold", endres, 32'h99999999);
    step();
    en = 1'b1; dly = 4'd0;
    @(negedge clk);
    chk1("enlow_idle_start", f_start, 1'b1);
    chk("enlow_res", endres, 32'h44444444);
    step();
    en = 1'b0;

    // performance counters from a clean reset
    rst_n = 1'b0;
    @(negedge clk);
    chk("prst_endres", endres, 32'h0);
    step();
    rst_n = 1'b1;
    run_vec('{2'b00, 4'd4, 32'h600DF00D, 32'h0, 32'h0, 32'h600DF00D, 1'b0});
`ifdef IBEX_EFPGA_PERF_EN
    chk("perf_busy", busy_c, 32'd4);
    chk("perf_ops", ops_c, 32'd1);
`else
    chk("perf_busy", busy_c, 32'd0);
    chk("perf_ops", ops_c, 32'd0);
`endif
    step();
    en = 1'b1; dly = 4'd4;
    step(); step();
    rst_n = 1'b0; en = 1'b0;
    @(negedge clk);
    chk("mid_rst_busy", busy_c, 32'd0);
    chk("mid_rst_ops", ops_c, 32'd0);
    step();
    rst_n = 1'b1;
    rdy_pat = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      rdy_pat[c] = ready;
      step();
    end
    chk("mid_rst_no_ready", 32'(rdy_pat), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
